// File: rtl/gpio_pkg.sv
// Shared definitions for the banked GPIO peripheral: register indices,
// edge-polarity encodings and the bank-select width helper.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_PIN    = 3'd0,
    REG_DIR    = 3'd1,
    REG_OUT    = 3'd2,
    REG_IEN    = 3'd3,
    REG_IFLAG  = 3'd4,
    REG_EDGE   = 3'd5,
    REG_BOTH   = 3'd6,
    REG_TOGGLE = 3'd7
  } gpio_reg_e;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // A single bank still carries one (ignored) select bit so addr is never zero-width.
  function automatic int bank_bits(input int banks);
    return (banks <= 1) ? 1 : $clog2(banks);
  endfunction

endpackage

// File: rtl/gpio_port_if.sv
// CPU-side bus of the GPIO peripheral: chip select, write strobe, address,
// data in both directions and the interrupt request.
interface gpio_port_if #(
  parameter int BW = 1
);
  logic          cs;
  logic          we;
  logic [BW+2:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          irq;

  modport master (output cs, output we, output addr, output din, input dout, input irq);
  modport slave  (input cs, input we, input addr, input din, output dout, output irq);
endinterface

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser followed by a rise/fall/any-edge detector that
// compares the last sync stage with one extra delayed copy.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  input  logic [WIDTH-1:0] i_edge_sel,
  input  logic [WIDTH-1:0] i_both,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_event
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      logic [SYNC_STAGES-1:0] r_chain;
      logic                   r_prev;
      logic                   w_rise;
      logic                   w_fall;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_chain <= '0;
          r_prev  <= 1'b0;
        end else begin
          r_chain <= {r_chain[SYNC_STAGES-2:0], i_async[gi]};
          r_prev  <= r_chain[SYNC_STAGES-1];
        end
      end

      assign w_rise      = r_chain[SYNC_STAGES-1] & ~r_prev;
      assign w_fall      = ~r_chain[SYNC_STAGES-1] & r_prev;
      assign o_sync[gi]  = r_chain[SYNC_STAGES-1];
      assign o_event[gi] = i_both[gi] ? (w_rise | w_fall)
                         : (i_edge_sel[gi] == EDGE_FALL) ? w_fall : w_rise;
    end
  endgenerate

endmodule

// File: rtl/gpio_port.sv
// Banked memory-mapped GPIO: per-pin direction, output latch with toggle writes,
// synchronised inputs and edge-triggered interrupt flags with W1C clearing.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe
);

  localparam int BANKS   = WIDTH / 8;
  localparam int BW      = bank_bits(BANKS);
  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [WIDTH-1:0] r_out, r_dir, r_ien, r_iflag, r_edge, r_both;
  logic [2:0]       r_arm_cnt;
  logic [7:0]       r_dout;
  logic             r_irq;

  gpio_reg_e        w_reg;
  logic [BW-1:0]    w_bank;
  logic [BW-1:0]    w_bank_idx;
  logic             w_bank_ok;
  logic             w_wr;
  logic             w_rd;
  logic             w_armed;
  logic [WIDTH-1:0] w_sync, w_event;
  logic [WIDTH-1:0] w_out_next, w_dir_next, w_ien_next, w_edge_next, w_both_next, w_w1c;
  logic [BANKS-1:0][7:0] w_rd_bytes;
  logic [7:0]       w_rd_data;

  assign w_reg      = gpio_reg_e'(bus.addr[BW+2:BW]);
  assign w_bank     = bus.addr[BW-1:0];
  assign w_bank_idx = (BANKS == 1) ? '0 : w_bank;
  assign w_bank_ok  = (BANKS == 1) || ({1'b0, w_bank} < (BW+1)'(BANKS));
  assign w_wr       = bus.cs & bus.we;
  assign w_rd       = bus.cs & ~bus.we;
  assign w_armed    = (r_arm_cnt == 3'(ARM_MAX));

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .i_async    (gpio_i),
    .i_edge_sel (r_edge),
    .i_both     (r_both),
    .o_sync     (w_sync),
    .o_event    (w_event)
  );

  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic w_sel;
      assign w_sel = w_wr && w_bank_ok && (w_bank_idx == BW'(gi));

      // PIN and OUT writes both load the latch; TOGGLE flips the bits set in din.
      assign w_out_next[8*gi +: 8] =
          !w_sel                                     ? r_out[8*gi +: 8]
        : (w_reg == REG_PIN || w_reg == REG_OUT)     ? bus.din
        : (w_reg == REG_TOGGLE)                      ? (r_out[8*gi +: 8] ^ bus.din)
        :                                              r_out[8*gi +: 8];

      assign w_dir_next[8*gi +: 8]  = (w_sel && w_reg == REG_DIR)  ? bus.din : r_dir[8*gi +: 8];
      assign w_ien_next[8*gi +: 8]  = (w_sel && w_reg == REG_IEN)  ? bus.din : r_ien[8*gi +: 8];
      assign w_edge_next[8*gi +: 8] = (w_sel && w_reg == REG_EDGE) ? bus.din : r_edge[8*gi +: 8];
      assign w_both_next[8*gi +: 8] = (w_sel && w_reg == REG_BOTH) ? bus.din : r_both[8*gi +: 8];
      assign w_w1c[8*gi +: 8]       = (w_sel && w_reg == REG_IFLAG) ? bus.din : 8'h00;

      assign w_rd_bytes[gi] =
          (w_reg == REG_PIN)   ? w_sync[8*gi +: 8]
        : (w_reg == REG_DIR)   ? r_dir[8*gi +: 8]
        : (w_reg == REG_OUT)   ? r_out[8*gi +: 8]
        : (w_reg == REG_IEN)   ? r_ien[8*gi +: 8]
        : (w_reg == REG_IFLAG) ? r_iflag[8*gi +: 8]
        : (w_reg == REG_EDGE)  ? r_edge[8*gi +: 8]
        : (w_reg == REG_BOTH)  ? r_both[8*gi +: 8]
        :                        8'h00;
    end
  endgenerate

  always_comb begin
    w_rd_data = 8'h00;
    for (int b = 0; b < BANKS; b++) begin
      if (w_bank_ok && w_bank_idx == BW'(b)) begin
        w_rd_data = w_rd_bytes[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_ien     <= '0;
      r_iflag   <= '0;
      r_edge    <= '0;
      r_both    <= '0;
      r_arm_cnt <= '0;
      r_dout    <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_dir  <= w_dir_next;
      r_ien  <= w_ien_next;
      r_edge <= w_edge_next;
      r_both <= w_both_next;
      // Set has priority over a same-cycle W1C; edges are masked until the sync chain is primed.
      r_iflag <= (r_iflag & ~w_w1c) | (w_event & {WIDTH{w_armed}});
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 3'd1;
      end
      if (w_rd) begin
        r_dout <= w_rd_data;
      end
      r_irq <= |(r_iflag & r_ien);
    end
  end

  assign bus.dout = r_dout;
  assign bus.irq  = r_irq;
  assign gpio_o   = r_out;
  assign gpio_oe  = r_dir;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for a 16-pin, 2-stage-sync gpio_port: register access,
// input/flag/irq latency, edge selection, W1C priority and reset arming.
module tb_gpio_port;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] gpio_i = 16'h0000;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;
  int          n_checks = 0;
  int          n_fail = 0;

  gpio_port_if #(.BW(1)) bus ();

  gpio_port #(
    .WIDTH       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input gpio_reg_e r, input logic bank, input logic [7:0] d);
    bus.cs   = 1'b1;
    bus.we   = 1'b1;
    bus.addr = {r, bank};
    bus.din  = d;
    tick(1);
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
    $display("wr  reg=%0d bank=%0d data=0x%02h", r, bank, d);
  endtask

  task automatic rd_check(input string tag, input gpio_reg_e r, input logic bank, input logic [7:0] exp);
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = {r, bank};
    tick(1);
    bus.cs   = 1'b0;
    $display("rd  reg=%0d bank=%0d data=0x%02h", r, bank, bus.dout);
    check(tag, {8'h00, bus.dout}, {8'h00, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = 8'h00;

    // Reset state
    tick(3);
    check("rst_gpio_o", gpio_o, 16'h0000);
    check("rst_gpio_oe", gpio_oe, 16'h0000);
    check("rst_irq", {15'd0, bus.irq}, 16'h0000);
    check("rst_dout", {8'h00, bus.dout}, 16'h0000);
    reset = 1'b1;
    tick(1);
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 2; b++) begin
        rd_check("rst_read", gpio_reg_e'(r), b[0], 8'h00);
      end
    end
    check("rst_irq_after", {15'd0, bus.irq}, 16'h0000);

    // Direction, output latch and toggle
    wr(REG_DIR, 1'b0, 8'hF0);
    wr(REG_OUT, 1'b0, 8'hA5);
    check("out_a5", gpio_o, 16'h00A5);
    wr(REG_TOGGLE, 1'b0, 8'hFF);
    check("gpio_oe", gpio_oe, 16'h00F0);
    check("gpio_o_toggled", gpio_o, 16'h005A);
    rd_check("out_readback", REG_OUT, 1'b0, 8'h5A);
    rd_check("toggle_reads_zero", REG_TOGGLE, 1'b0, 8'h00);
    rd_check("dir_readback", REG_DIR, 1'b0, 8'hF0);
    wr(REG_PIN, 1'b1, 8'h3C);
    check("pin_write_bank1", gpio_o, 16'h3C5A);

    // Input -> PIN -> IFLAG -> irq latency on bank 1
    wr(REG_IEN, 1'b1, 8'h01);
    gpio_i = 16'h0100;
    tick(1);
    rd_check("pin_before_sync", REG_PIN, 1'b1, 8'h00);
    rd_check("iflag_before_set", REG_IFLAG, 1'b1, 8'h00);
    check("irq_lags_flag", {15'd0, bus.irq}, 16'h0000);
    rd_check("pin_synced", REG_PIN, 1'b1, 8'h01);
    check("irq_set", {15'd0, bus.irq}, 16'h0001);
    rd_check("iflag_set", REG_IFLAG, 1'b1, 8'h01);
    wr(REG_IFLAG, 1'b1, 8'h01);
    check("irq_lags_clear", {15'd0, bus.irq}, 16'h0001);
    tick(1);
    check("irq_cleared", {15'd0, bus.irq}, 16'h0000);
    rd_check("iflag_cleared", REG_IFLAG, 1'b1, 8'h00);

    // Edge selection: pin0 falling only, pin1 any edge
    wr(REG_EDGE, 1'b0, 8'h01);
    wr(REG_BOTH, 1'b0, 8'h02);
    gpio_i[0] = 1'b1;
    tick(5);
    rd_check("fall_sel_ignores_rise", REG_IFLAG, 1'b0, 8'h00);
    gpio_i[0] = 1'b0;
    tick(5);
    rd_check("fall_sel_sets", REG_IFLAG, 1'b0, 8'h01);
    wr(REG_IFLAG, 1'b0, 8'h01);
    gpio_i[1] = 1'b1;
    tick(5);
    rd_check("both_rise", REG_IFLAG, 1'b0, 8'h02);
    wr(REG_IFLAG, 1'b0, 8'h02);
    rd_check("both_w1c", REG_IFLAG, 1'b0, 8'h00);
    gpio_i[1] = 1'b0;
    tick(5);
    rd_check("both_fall", REG_IFLAG, 1'b0, 8'h02);
    wr(REG_IFLAG, 1'b0, 8'h02);

    // Same-cycle W1C and rising edge on pin0: set wins
    wr(REG_EDGE, 1'b0, 8'h00);
    gpio_i[0] = 1'b1;
    tick(5);
    rd_check("rise_sets", REG_IFLAG, 1'b0, 8'h01);
    gpio_i[0] = 1'b0;
    tick(5);
    rd_check("fall_no_set", REG_IFLAG, 1'b0, 8'h01);
    gpio_i[0] = 1'b1;
    tick(2);
    wr(REG_IFLAG, 1'b0, 8'h01);
    rd_check("set_beats_w1c", REG_IFLAG, 1'b0, 8'h01);
    wr(REG_IFLAG, 1'b0, 8'h01);
    rd_check("plain_w1c", REG_IFLAG, 1'b0, 8'h00);

    // Mid-operation reset with all pins high, then arming
    gpio_i = 16'hFFFF;
    tick(4);
    reset = 1'b0;
    tick(2);
    check("midrst_gpio_o", gpio_o, 16'h0000);
    check("midrst_gpio_oe", gpio_oe, 16'h0000);
    reset = 1'b1;
    tick(6);
    rd_check("arm_iflag_b0", REG_IFLAG, 1'b0, 8'h00);
    rd_check("arm_iflag_b1", REG_IFLAG, 1'b1, 8'h00);
    rd_check("arm_pin_b0", REG_PIN, 1'b0, 8'hFF);
    rd_check("arm_edge_reset", REG_EDGE, 1'b0, 8'h00);
    gpio_i[3] = 1'b0;
    tick(4);
    gpio_i[3] = 1'b1;
    tick(5);
    rd_check("pulse_pin3_b0", REG_IFLAG, 1'b0, 8'h08);
    rd_check("pulse_pin3_b1", REG_IFLAG, 1'b1, 8'h00);
    check("irq_ien_reset", {15'd0, bus.irq}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
